// File: rtl/display_scheduler.sv
// display_scheduler: chooses what the four-digit display shows.
// The default view is the beat (current beat, loop bound). A change on
// volume, octave or loop width raises a timed overlay for that parameter.
// The beat and bound are converted to decimal by a repeated-subtract engine.
module display_scheduler #(
  parameter int unsigned HOLD_TICKS = 200,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [2:0]  volume,
  input  logic [2:0]  octave,
  input  logic [2:0]  loop_width,
  input  logic [11:0] ibeat,
  input  logic [11:0] bound,
  output logic [15:0] digit_code,
  output logic [1:0]  view,
  output logic        update
);

  localparam logic [1:0] V_BEAT = 2'd0;
  localparam logic [1:0] V_VOL  = 2'd1;
  localparam logic [1:0] V_OCT  = 2'd2;
  localparam logic [1:0] V_LOOP = 2'd3;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_LOAD = 2'd1;
  localparam logic [1:0] C_DIV  = 2'd2;
  localparam logic [1:0] C_DONE = 2'd3;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic              primed;
  logic [2:0]        vol_q, oct_q, lw_q;
  logic              ev_vol, ev_oct, ev_loop;
  logic [1:0]        state;
  logic [HOLD_W-1:0] hold;

  logic [1:0]        cstate;
  logic [6:0]        b_rem, d_rem;
  logic [3:0]        b_tens, d_tens;
  logic              b_big, d_big;
  logic              b_ge, d_ge;
  logic [6:0]        b_rem_nx, d_rem_nx;
  logic [15:0]       beat_digits;

  logic [2:0]        param_val;
  logic [15:0]       dc_next;

  // Copies of the parameters; the first cycle after reset only primes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
      vol_q  <= '0;
      oct_q  <= '0;
      lw_q   <= '0;
    end else begin
      primed <= 1'b1;
      vol_q  <= volume;
      oct_q  <= octave;
      lw_q   <= loop_width;
    end
  end

  // Parameter-change events, suppressed until the copies are primed
  always_comb begin
    ev_vol  = primed && (volume != vol_q);
    ev_oct  = primed && (octave != oct_q);
    ev_loop = primed && (loop_width != lw_q);
  end

  // View FSM: events (VOL > OCT > LOOP) reload the hold, ticks count it down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= V_BEAT;
      hold  <= '0;
    end else if (ev_vol) begin
      state <= V_VOL;
      hold  <= HOLD_LOAD;
    end else if (ev_oct) begin
      state <= V_OCT;
      hold  <= HOLD_LOAD;
    end else if (ev_loop) begin
      state <= V_LOOP;
      hold  <= HOLD_LOAD;
    end else if (state != V_BEAT && tick) begin
      hold <= hold - HOLD_ONE;
      if (hold == HOLD_ONE) state <= V_BEAT;
    end
  end

  // Next remainders for one divide step; a remainder below 10 is left alone
  always_comb begin
    b_ge     = (b_rem >= 7'd10);
    d_ge     = (d_rem >= 7'd10);
    b_rem_nx = b_ge ? (b_rem - 7'd10) : b_rem;
    d_rem_nx = d_ge ? (d_rem - 7'd10) : d_rem;
  end

  // Free-running converter: IDLE -> LOAD -> DIV -> DONE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cstate      <= C_IDLE;
      b_rem       <= '0;
      d_rem       <= '0;
      b_tens      <= '0;
      d_tens      <= '0;
      b_big       <= 1'b0;
      d_big       <= 1'b0;
      beat_digits <= 16'hAAAA;
    end else begin
      case (cstate)
        C_IDLE: cstate <= C_LOAD;
        C_LOAD: begin
          b_big  <= (ibeat > 12'd99);
          d_big  <= (bound > 12'd99);
          b_rem  <= (ibeat > 12'd99) ? '0 : ibeat[6:0];
          d_rem  <= (bound > 12'd99) ? '0 : bound[6:0];
          b_tens <= '0;
          d_tens <= '0;
          cstate <= C_DIV;
        end
        C_DIV: begin
          // The exit test looks at the post-step remainders so 99 takes 9 cycles
          b_rem  <= b_rem_nx;
          d_rem  <= d_rem_nx;
          b_tens <= b_tens + {3'b000, b_ge};
          d_tens <= d_tens + {3'b000, d_ge};
          if (b_rem_nx < 7'd10 && d_rem_nx < 7'd10) cstate <= C_DONE;
        end
        default: begin
          beat_digits <= {b_big ? 4'hA : b_tens, b_big ? 4'hA : b_rem[3:0],
                          d_big ? 4'hA : d_tens, d_big ? 4'hA : d_rem[3:0]};
          cstate      <= C_IDLE;
        end
      endcase
    end
  end

  // Overlay contents and output selection
  always_comb begin
    case (state)
      V_VOL:   param_val = volume;
      V_OCT:   param_val = octave;
      default: param_val = loop_width;
    endcase
    if (state == V_BEAT) dc_next = beat_digits;
    else                 dc_next = {2'b00, state, 4'hA, 4'hF, 1'b0, param_val};
  end

  // Registered display word with a pulse on every value change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_code <= 16'hAAAA;
      update     <= 1'b0;
    end else begin
      digit_code <= dc_next;
      update     <= (dc_next != digit_code);
    end
  end

  assign view = state;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed scenarios plus random traffic, checked
// against a cycle-level model of the view rules and decimal digit rules.
module tb_display_scheduler;

  localparam int HOLD = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  volume = 3'd3, octave = 3'd2, loop_width = 3'd1;
  logic [11:0] ibeat = 12'd37, bound = 12'd64;
  logic [15:0] digit_code;
  logic [1:0]  view;
  logic        update;

  int total = 0;
  int bad = 0;

  display_scheduler #(.HOLD_TICKS(HOLD), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .volume(volume), .octave(octave),
    .loop_width(loop_width), .ibeat(ibeat), .bound(bound),
    .digit_code(digit_code), .view(view), .update(update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] two_digits(input int v);
    if (v > 99) return 8'hAA;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // ---------------- reference model ----------------
  int          m_view = 0, m_hold = 0;
  bit          m_primed = 0;
  logic [2:0]  m_vol, m_oct, m_lw;
  bit          exp_ov_valid = 0;
  logic [15:0] exp_ov;
  int          stable = 0;
  logic [11:0] last_ib, last_bd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_view = 0; m_hold = 0; m_primed = 0;
      exp_ov_valid = 0; stable = 0;
      last_ib = ibeat; last_bd = bound;
    end else begin
      logic [2:0] pv;
      bit ev_v, ev_o, ev_l;
      // output word registered at this edge reflects the view held before it
      pv = (m_view == 1) ? volume : (m_view == 2) ? octave : loop_width;
      exp_ov_valid = (m_view != 0);
      exp_ov = {4'(m_view), 4'hA, 4'hF, 1'b0, pv};
      if (ibeat == last_ib && bound == last_bd) stable++;
      else stable = 0;
      last_ib = ibeat; last_bd = bound;
      ev_v = m_primed && volume != m_vol;
      ev_o = m_primed && octave != m_oct;
      ev_l = m_primed && loop_width != m_lw;
      m_primed = 1;
      m_vol = volume; m_oct = octave; m_lw = loop_width;
      if (ev_v)      begin m_view = 1; m_hold = HOLD; end
      else if (ev_o) begin m_view = 2; m_hold = HOLD; end
      else if (ev_l) begin m_view = 3; m_hold = HOLD; end
      else if (m_view != 0 && tick) begin
        m_hold--;
        if (m_hold == 0) m_view = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [15:0] prev_dc = 16'hAAAA;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_digits", 32'(digit_code), 32'hAAAA);
      chk("rst_view", 32'(view), 32'd0);
      chk("rst_update", 32'(update), 32'd0);
      prev_dc = 16'hAAAA;
    end else begin
      chk("view", 32'(view), 32'(m_view));
      chk("update", 32'(update), 32'(digit_code != prev_dc));
      if (exp_ov_valid)
        chk("overlay_digits", 32'(digit_code), 32'(exp_ov));
      else if (stable >= 28)
        chk("beat_digits", 32'(digit_code),
            32'({two_digits(int'(last_ib)), two_digits(int'(last_bd))}));
      prev_dc = digit_code;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_digits(input string name, input logic [15:0] exp, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (digit_code == exp) seen = 1;
    end
    chk(name, 32'(digit_code), 32'(exp));
  endtask

  initial begin
    int first_hit, upd_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // power-up: beat view settles to 37/64 with a single update pulse
    first_hit = -1; upd_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (update) upd_cnt++;
      if (first_hit < 0 && digit_code == 16'h3764) first_hit = i;
    end
    chk("init_digits", 32'(digit_code), 32'h3764);
    chk("init_within_16", 32'(first_hit >= 0 && first_hit < 16), 32'd1);
    chk("init_update_pulses", 32'(upd_cnt), 32'd1);
    chk("init_view", 32'(view), 32'd0);

    // volume overlay and its 200-tick hold
    volume = 3'd5;
    @(negedge clk); chk("vol_view", 32'(view), 32'd1);
    @(negedge clk); chk("vol_digits", 32'(digit_code), 32'h1AF5);
    do_ticks(HOLD - 1);
    chk("vol_hold_199", 32'(view), 32'd1);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    chk("vol_expired", 32'(view), 32'd0);
    @(negedge clk); chk("vol_back_beat", 32'(digit_code), 32'h3764);

    // octave and loop_width together: octave wins
    octave = 3'd6; loop_width = 3'd4;
    @(negedge clk); chk("oct_view", 32'(view), 32'd2);
    @(negedge clk); chk("oct_digits", 32'(digit_code), 32'h2AF6);
    loop_width = 3'd5;
    @(negedge clk); chk("loop_view", 32'(view), 32'd3);
    @(negedge clk); chk("loop_digits", 32'(digit_code), 32'h3AF5);

    // hold=1, repeated event coincides with tick: event reloads
    do_ticks(HOLD - 1);
    chk("loop_hold_1", 32'(view), 32'd3);
    loop_width = 3'd6; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("coincide_view", 32'(view), 32'd3);
    @(negedge clk); chk("coincide_digits", 32'(digit_code), 32'h3AF6);
    do_ticks(HOLD - 1);
    chk("reload_hold", 32'(view), 32'd3);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    chk("reload_expired", 32'(view), 32'd0);

    // out-of-range bound, then the largest in-range beat
    ibeat = 12'd9; bound = 12'd150;
    wait_digits("big_bound", 16'h09AA, 30);
    ibeat = 12'd99;
    wait_digits("beat_99", 16'h99AA, 20);

    // reset mid-conversion while the volume overlay is up
    bound = 12'd99;
    repeat (30) @(negedge clk);
    volume = 3'd7;
    repeat (3) @(negedge clk);
    chk("pre_reset_view", 32'(view), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digit_code), 32'hAAAA);
    chk("async_rst_view", 32'(view), 32'd0);
    chk("async_rst_update", 32'(update), 32'd0);
    repeat (2) @(negedge clk);
    volume = 3'd4;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_event", 32'(view), 32'd0);
    end
    wait_digits("post_rst_beat", 16'h9999, 30);

    // random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) ibeat = 12'($urandom_range(0, 150));
      if ($urandom_range(0, 39) == 0) bound = 12'($urandom_range(0, 150));
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0: volume = 3'($urandom_range(0, 7));
          1: octave = 3'($urandom_range(0, 7));
          2: loop_width = 3'($urandom_range(0, 7));
          default: begin
            volume = 3'($urandom_range(0, 7));
            octave = 3'($urandom_range(0, 7));
            loop_width = 3'($urandom_range(0, 7));
          end
        endcase
      end
      @(negedge clk);
    end
    tick = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
